ps2_rx_buffered: RTL and testbench

PS2_RX_BUFFERED -- requirements
Module: ps2_rx_buffered

---
 rtl/ps2_pkg.sv | 18 +
 rtl/ps2_sync_fifo.sv | 76 +++++++
 rtl/ps2_rx_buffered.sv | 191 +++++++++++++++++++
 tb/tb_ps2_rx_buffered.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg -- shared definitions for the buffered PS/2 receiver.
//   rx_state_e : receive FSM states (IDLE, DATA, PARITY, STOP)
//   FRAME_BITS : bits per PS/2 frame (start, 8 data, parity, stop)
//   DATA_W     : payload width of one frame
package ps2_pkg;

    localparam int FRAME_BITS = 11;
    // Start, parity and stop bits wrap the payload.
    localparam int DATA_W     = FRAME_BITS - 3;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

endpackage

// File: rtl/ps2_sync_fifo.sv
// ps2_sync_fifo -- single-clock show-ahead FIFO.
//   clk, reset      : system clock, asynchronous active-low reset
//   push, push_data : write request and data
//   pop             : consume the head entry (ignored when empty)
//   rd_data, valid  : head entry (0 when empty) and non-empty flag
//   count           : current occupancy, 0..DEPTH
//   overflow        : one-cycle pulse when a push is dropped on a full FIFO
module ps2_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             full, wr_en, rd_en;

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        full  = (count_q == CW'(DEPTH));
        rd_en = pop && (count_q != '0);
        // A full FIFO still accepts a push when the head is popped that cycle.
        wr_en = push && (!full || rd_en);

        wr_ptr_d   = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = count_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
        overflow_d = push && full && !rd_en;
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge value of its inputs regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: storage is deliberately not reset; emptiness is tracked by the
    // pointers and count, and rd_data is masked to 0 while empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign valid    = (count_q != '0);
    assign rd_data  = valid ? mem_q[rd_ptr_q] : '0;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/ps2_rx_buffered.sv
// ps2_rx_buffered -- PS/2 device-to-host receiver with a receive FIFO.
//   clk, reset          : system clock, asynchronous active-low reset
//   ps2_clk, ps2_data   : asynchronous PS/2 lines
//   m_data, m_valid     : show-ahead head byte and non-empty flag
//   m_ready             : consumer accepts the head byte
//   fifo_count          : FIFO occupancy
//   parity_err          : one-cycle pulse on an odd-parity failure
//   frame_err           : one-cycle pulse on a bad stop bit or timeout
//   overflow            : one-cycle pulse when a good byte is dropped
// Build option: define PS2_RX_PARITY_CHECK_EN to enable parity checking;
// otherwise the parity bit is consumed but ignored and parity_err stays 0.
module ps2_rx_buffered
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 2000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    output logic [DATA_W-1:0]             m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow
);

`ifdef PS2_RX_PARITY_CHECK_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    localparam int FW    = $clog2(FILTER_LEN + 1);
    localparam int BW    = $clog2(DATA_W);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic              clk_meta_q, clk_meta_d, clk_sync_q, clk_sync_d;
    logic              data_meta_q, data_meta_d, data_sync_q, data_sync_d;
    logic              filt_q, filt_d, filt_prev_q, filt_prev_d;
    logic [FW-1:0]     filt_cnt_q, filt_cnt_d;
    rx_state_e         state_q, state_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_ok_q, par_ok_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic              push_q, push_d;
    logic              parity_err_q, parity_err_d;
    logic              frame_err_q, frame_err_d;
    logic              rise;

    assign rise = filt_q && !filt_prev_q;

    always_comb begin
        clk_meta_d   = ps2_clk;
        clk_sync_d   = clk_meta_q;
        data_meta_d  = ps2_data;
        data_sync_d  = data_meta_q;
        filt_d       = filt_q;
        filt_cnt_d   = '0;
        filt_prev_d  = filt_q;
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_ok_d     = par_ok_q;
        tmo_cnt_d    = '0;
        push_d       = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;

        // The filtered level flips only after FILTER_LEN consecutive
        // synchronised samples disagree with it.
        if (clk_sync_q != filt_q) begin
            if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = clk_sync_q;
            end else begin
                filt_cnt_d = filt_cnt_q + FW'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (rise && !data_sync_q) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (rise) begin
                    shift_d = {data_sync_q, shift_q[DATA_W-1:1]};
                    if (bit_cnt_q == BW'(DATA_W - 1)) begin
                        state_d   = PARITY;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (rise) begin
                    par_ok_d = ^{shift_q, data_sync_q};
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (rise) begin
                    state_d = IDLE;
                    if (!data_sync_q) begin
                        frame_err_d = 1'b1;
                    end else if (PARITY_EN && !par_ok_q) begin
                        parity_err_d = 1'b1;
                    end else begin
                        push_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A stalled frame is abandoned; this overrides the case above.
        if (state_q != IDLE && !rise) begin
            if (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                frame_err_d = 1'b1;
                state_d     = IDLE;
                bit_cnt_d   = '0;
            end else begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_meta_q   <= 1'b1;
            clk_sync_q   <= 1'b1;
            data_meta_q  <= 1'b1;
            data_sync_q  <= 1'b1;
            filt_q       <= 1'b1;
            filt_cnt_q   <= '0;
            filt_prev_q  <= 1'b1;
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_ok_q     <= 1'b0;
            tmo_cnt_q    <= '0;
            push_q       <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            clk_meta_q   <= clk_meta_d;
            clk_sync_q   <= clk_sync_d;
            data_meta_q  <= data_meta_d;
            data_sync_q  <= data_sync_d;
            filt_q       <= filt_d;
            filt_cnt_q   <= filt_cnt_d;
            filt_prev_q  <= filt_prev_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_ok_q     <= par_ok_d;
            tmo_cnt_q    <= tmo_cnt_d;
            push_q       <= push_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // shift_q is untouched in IDLE, so it still holds the byte on push_q.
    ps2_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_q),
        .push_data (shift_q),
        .pop       (m_ready),
        .rd_data   (m_data),
        .valid     (m_valid),
        .count     (fifo_count),
        .overflow  (overflow)
    );

    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_rx_buffered.sv
// Self-checking bench for ps2_rx_buffered with default parameters.
module tb_ps2_rx_buffered;

    localparam int FIFO_DEPTH  = 8;
    localparam int FILTER_LEN  = 4;
    localparam int TIMEOUT_CYC = 2000;
    localparam int HALF        = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
    logic       m_valid;
    logic [3:0] fifo_count;
    logic       parity_err, frame_err, overflow;

    int n_checks = 0;
    int n_errors = 0;
    int par_cnt = 0;
    int frm_cnt = 0;
    int ovf_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    ps2_rx_buffered #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .fifo_count (fifo_count),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Pulse counters and scoreboard compare on every accepted byte.
    always @(negedge clk) begin
        if (reset) begin
            if (parity_err) par_cnt++;
            if (frame_err)  frm_cnt++;
            if (overflow)   ovf_cnt++;
            if (m_valid && m_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_byte: got %02h, expected none", m_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (m_data !== mon_exp) begin
                        n_errors++;
                        $display("FAIL rx_byte: got %02h, expected %02h", m_data, mon_exp);
                    end
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic send_bit(input logic b);
        @(posedge clk); #1;
        ps2_data = b;
        ps2_clk  = 1'b0;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b1;
        repeat (HALF) @(posedge clk);
    endtask

    // Sends the first nbits of a frame (11 = complete frame).
    task automatic send_frame(input logic [7:0] d, input logic par_flip,
                              input logic stop_b, input int nbits);
        logic [10:0] bits;
        bits = {stop_b, (~^d) ^ par_flip, d, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(bits[i]);
        #1 ps2_data = 1'b1;
        repeat (HALF) @(posedge clk);
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk); #1 m_ready = r;
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((exp_q.size() != 0 || m_valid) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (exp_q.size() != 0 || m_valid) begin
            n_errors++;
            $display("FAIL drain_timeout: pending %0d, m_valid %b, expected 0 and 0",
                     exp_q.size(), m_valid);
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (m_valid !== 1'b0 || m_data !== 8'h00 || fifo_count !== 4'd0) begin
            n_errors++;
            $display("FAIL reset_fifo: valid %b data %02h count %0d, expected 0 00 0",
                     m_valid, m_data, fifo_count);
        end
        n_checks++;
        if ({parity_err, frame_err, overflow} !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_pulses: got %b, expected 000",
                     {parity_err, frame_err, overflow});
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] bytes [5] = '{8'h45, 8'h35, 8'h55, 8'hAA, 8'hFF};
        int p0 = par_cnt, f0 = frm_cnt, o0 = ovf_cnt;
        set_ready(1'b1);
        foreach (bytes[i]) begin
            exp_q.push_back(bytes[i]);
            send_frame(bytes[i], 1'b0, 1'b1, 11);
        end
        wait_drain();
        n_checks++;
        if (par_cnt != p0 || frm_cnt != f0 || ovf_cnt != o0) begin
            n_errors++;
            $display("FAIL basic_pulses: par %0d frm %0d ovf %0d, expected 0 0 0",
                     par_cnt - p0, frm_cnt - f0, ovf_cnt - o0);
        end
    endtask

    task automatic test_overflow();
        int o0 = ovf_cnt;
        set_ready(1'b0);
        for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
            if (i < FIFO_DEPTH) exp_q.push_back(8'(8'h11 * (i + 1)));
            send_frame(8'(8'h11 * (i + 1)), 1'b0, 1'b1, 11);
            if (i == FIFO_DEPTH - 1) begin
                n_checks++;
                if (fifo_count !== 4'd8 || ovf_cnt != o0) begin
                    n_errors++;
                    $display("FAIL fill_full: count %0d ovf %0d, expected 8 0",
                             fifo_count, ovf_cnt - o0);
                end
            end
        end
        n_checks++;
        if (fifo_count !== 4'd8 || ovf_cnt != o0 + 1) begin
            n_errors++;
            $display("FAIL overflow: count %0d ovf %0d, expected 8 1",
                     fifo_count, ovf_cnt - o0);
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== 8'h11) begin
            n_errors++;
            $display("FAIL hold_head: valid %b data %02h, expected 1 11", m_valid, m_data);
        end
        set_ready(1'b1);
        wait_drain();
        n_checks++;
        if (fifo_count !== 4'd0) begin
            n_errors++;
            $display("FAIL drain_count: got %0d, expected 0", fifo_count);
        end
    endtask

    task automatic test_parity();
        int p0 = par_cnt;
        set_ready(1'b0);
`ifdef PS2_RX_PARITY_CHECK_EN
        send_frame(8'hAA, 1'b1, 1'b1, 11);
        n_checks++;
        if (par_cnt != p0 + 1 || fifo_count !== 4'd0) begin
            n_errors++;
            $display("FAIL parity_err: pulses %0d count %0d, expected 1 0",
                     par_cnt - p0, fifo_count);
        end
`else
        exp_q.push_back(8'hAA);
        send_frame(8'hAA, 1'b1, 1'b1, 11);
        n_checks++;
        if (par_cnt != p0 || fifo_count !== 4'd1) begin
            n_errors++;
            $display("FAIL parity_ignored: pulses %0d count %0d, expected 0 1",
                     par_cnt - p0, fifo_count);
        end
`endif
        set_ready(1'b1);
        wait_drain();
    endtask

    task automatic test_frame_err();
        int f0 = frm_cnt, p0 = par_cnt;
        set_ready(1'b0);
        send_frame(8'h55, 1'b0, 1'b0, 11);
        n_checks++;
        if (frm_cnt != f0 + 1 || par_cnt != p0 || fifo_count !== 4'd0) begin
            n_errors++;
            $display("FAIL stop_bit: frm %0d par %0d count %0d, expected 1 0 0",
                     frm_cnt - f0, par_cnt - p0, fifo_count);
        end
    endtask

    task automatic test_timeout();
        int f0 = frm_cnt;
        set_ready(1'b0);
        send_frame(8'h35, 1'b0, 1'b1, 5);
        repeat (TIMEOUT_CYC - 200) @(negedge clk);
        n_checks++;
        if (frm_cnt != f0) begin
            n_errors++;
            $display("FAIL early_timeout: frm %0d, expected 0", frm_cnt - f0);
        end
        repeat (300) @(negedge clk);
        n_checks++;
        if (frm_cnt != f0 + 1 || fifo_count !== 4'd0) begin
            n_errors++;
            $display("FAIL timeout: frm %0d count %0d, expected 1 0",
                     frm_cnt - f0, fifo_count);
        end
        set_ready(1'b1);
        exp_q.push_back(8'h35);
        send_frame(8'h35, 1'b0, 1'b1, 11);
        wait_drain();
        n_checks++;
        if (frm_cnt != f0 + 1) begin
            n_errors++;
            $display("FAIL after_timeout: frm %0d, expected 1", frm_cnt - f0);
        end
    endtask

    task automatic test_reset_midframe();
        int f0;
        set_ready(1'b0);
        send_frame(8'h01, 1'b0, 1'b1, 11);
        send_frame(8'h02, 1'b0, 1'b1, 11);
        send_frame(8'h03, 1'b0, 1'b1, 11);
        n_checks++;
        if (fifo_count !== 4'd3) begin
            n_errors++;
            $display("FAIL prefill: count %0d, expected 3", fifo_count);
        end
        send_frame(8'h5A, 1'b0, 1'b1, 5);
        @(posedge clk); #2 reset = 1'b0;
        #1;
        n_checks++;
        if (fifo_count !== 4'd0 || m_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL midframe_reset: count %0d valid %b, expected 0 0",
                     fifo_count, m_valid);
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        f0 = frm_cnt;
        set_ready(1'b1);
        exp_q.push_back(8'hFF);
        send_frame(8'hFF, 1'b0, 1'b1, 11);
        wait_drain();
        n_checks++;
        if (frm_cnt != f0) begin
            n_errors++;
            $display("FAIL resume_pulses: frm %0d, expected 0", frm_cnt - f0);
        end
    endtask

    task automatic test_glitch();
        int f0 = frm_cnt;
        set_ready(1'b1);
        @(posedge clk); #1;
        ps2_data = 1'b0;
        ps2_clk  = 1'b0;
        @(posedge clk); #1 ps2_clk = 1'b1;
        repeat (20) @(posedge clk);
        #1 ps2_data = 1'b1;
        repeat (TIMEOUT_CYC + 200) @(negedge clk);
        n_checks++;
        if (frm_cnt != f0 || fifo_count !== 4'd0) begin
            n_errors++;
            $display("FAIL glitch: frm %0d count %0d, expected 0 0",
                     frm_cnt - f0, fifo_count);
        end
        exp_q.push_back(8'h45);
        send_frame(8'h45, 1'b0, 1'b1, 11);
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_parity();
        test_frame_err();
        test_timeout();
        test_reset_midframe();
        test_glitch();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
